// File: rtl/rotor_phase_nco_if.sv
// rotor_phase_nco_if: speed/load command inputs and phase index outputs of the rotor NCO
interface rotor_phase_nco_if #(
  parameter int ACC_W = 24,
  parameter int ADDRW = 8,
  parameter int REV_W = 16
);
  logic             en;
  logic [ACC_W-1:0] step;
  logic             load;
  logic [ADDRW-1:0] load_angle;
  logic [ADDRW-1:0] sin_id;
  logic [ADDRW-1:0] cos_id;
  logic             tick;
  logic             wrap;
  logic [REV_W-1:0] rev_cnt;
  modport master (output en, step, load, load_angle, input sin_id, cos_id, tick, wrap, rev_cnt);
  modport slave (input en, step, load, load_angle, output sin_id, cos_id, tick, wrap, rev_cnt);
endinterface

// File: rtl/rotor_phase_nco.sv
// rotor_phase_nco: prescaled phase accumulator producing sine/cosine table indices; ROTOR_REV_COUNT_EN adds wrap strobe and revolution counter
module rotor_phase_nco #(
  parameter int ACC_W    = 24,
  parameter int ADDRW    = 8,
  parameter int PRESCALE = 100,
  parameter int REV_W    = 16
) (
  input  logic clk,
  input  logic rst,
  rotor_phase_nco_if.slave bus
);
  localparam int PW = $clog2(PRESCALE);
  localparam logic [ADDRW-1:0] QTR = ADDRW'(2 ** (ADDRW - 2));
  logic [PW-1:0]    pcnt;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] sum;
  logic [ACC_W-1:0] nacc;
  logic             last;
  logic             upd;
  assign last = pcnt == PW'(PRESCALE - 1);
  assign upd  = bus.en && last && !bus.load;
  assign sum  = acc + bus.step;
  assign nacc = bus.load ? {bus.load_angle, {(ACC_W - ADDRW){1'b0}}} : sum;
  // prescaler, accumulator and registered table indices; load overrides a coincident update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt       <= '0;
      acc        <= '0;
      bus.sin_id <= '0;
      bus.cos_id <= QTR;
      bus.tick   <= 1'b0;
    end else begin
      bus.tick <= upd;
      if (bus.load) pcnt <= '0;
      else if (bus.en) pcnt <= last ? '0 : pcnt + 1'b1;
      if (bus.load || upd) begin
        acc        <= nacc;
        bus.sin_id <= nacc[ACC_W-1 -: ADDRW];
        bus.cos_id <= nacc[ACC_W-1 -: ADDRW] + QTR;
      end
    end
  end
`ifdef ROTOR_REV_COUNT_EN
  logic fwd;
  logic rev;
  // an unsigned carry shows as a smaller sum, a borrow as a larger one
  assign fwd = !bus.step[ACC_W-1] && sum < acc;
  assign rev = bus.step[ACC_W-1] && sum > acc;
  // revolution tracking across accumulator wraps in either direction
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.wrap    <= 1'b0;
      bus.rev_cnt <= '0;
    end else begin
      bus.wrap <= upd && (fwd || rev);
      if (upd && fwd) bus.rev_cnt <= bus.rev_cnt + 1'b1;
      else if (upd && rev) bus.rev_cnt <= bus.rev_cnt - 1'b1;
    end
  end
`else
  assign bus.wrap    = 1'b0;
  assign bus.rev_cnt = '0;
`endif
endmodule
